// File: rtl/serial_word_receiver.sv
// Purpose : receive end of the board-to-board serial link; rebuilds an MSB-first
//           serial frame into a parallel word, checks the frame length and holds
//           the last good word for the display driver.
// Latency : word_valid / frame_error pulse on the edge that first samples ctrl low
//           (plus 2 cycles when RX_INPUT_SYNC_EN is defined).
// Backpressure: none; the far board free-runs and this block always accepts.
// Build option: define RX_INPUT_SYNC_EN to pass data/ctrl through 2-flop synchronisers.
// Ports:
//   Ten_MHz_input_clock  link clock, all logic on the rising edge
//   reset                synchronous, active-high
//   input_data_1_bit     serial data, MSB first
//   data_ctrl_input      frame enable, high for exactly WIDTH bits
//   word_out             last correctly received word
//   word_valid           1-cycle pulse when word_out updates
//   frame_error          1-cycle pulse on a short or overlong frame
//   busy                 high while a frame is being received
//   good_frames          accepted-frame count, wraps 255 -> 0
module serial_word_receiver #(
   parameter int WIDTH = 18,
   parameter int CNT_W = 5
) (
   input  logic             Ten_MHz_input_clock,
   input  logic             reset,
   input  logic             input_data_1_bit,
   input  logic             data_ctrl_input,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   output logic             frame_error,
   output logic             busy,
   output logic [7:0]       good_frames
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SHIFT   = 2'd1,
      S_OVERRUN = 2'd2
   } state_t;

   logic             w_ctrl_s;
   logic             w_data_s;
   logic [WIDTH-1:0] w_shift_next;

   state_t           r_state;
   logic             r_ctrl_prev;
   logic [WIDTH-1:0] r_shreg;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_word_out;
   logic             r_word_valid;
   logic             r_frame_error;
   logic             r_busy;
   logic [7:0]       r_good_frames;

`ifdef RX_INPUT_SYNC_EN
   // ctrl synchroniser resets high so a frame in flight at reset release
   // never looks like a fresh rising edge.
   logic [1:0] r_ctrl_sync;
   logic [1:0] r_data_sync;

   always_ff @(posedge Ten_MHz_input_clock) begin
      if (reset) begin
         r_ctrl_sync <= 2'b11;
         r_data_sync <= 2'b00;
      end else begin
         r_ctrl_sync <= {r_ctrl_sync[0], data_ctrl_input};
         r_data_sync <= {r_data_sync[0], input_data_1_bit};
      end
   end

   assign w_ctrl_s = r_ctrl_sync[1];
   assign w_data_s = r_data_sync[1];
`else
   assign w_ctrl_s = data_ctrl_input;
   assign w_data_s = input_data_1_bit;
`endif

   // Shift-in value; a 1-bit frame just takes the new bit.
   generate
      if (WIDTH == 1) begin : g_w1
         assign w_shift_next = w_data_s;
      end else begin : g_wn
         assign w_shift_next = {r_shreg[WIDTH-2:0], w_data_s};
      end
   endgenerate

   always_ff @(posedge Ten_MHz_input_clock) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_ctrl_prev   <= 1'b1;
         r_shreg       <= '0;
         r_cnt         <= '0;
         r_word_out    <= '0;
         r_word_valid  <= 1'b0;
         r_frame_error <= 1'b0;
         r_busy        <= 1'b0;
         r_good_frames <= 8'd0;
      end else begin
         r_ctrl_prev   <= w_ctrl_s;
         r_word_valid  <= 1'b0;
         r_frame_error <= 1'b0;

         case (r_state)
            S_IDLE: begin
               // Only a genuine low-to-high edge starts a frame.
               if (w_ctrl_s && !r_ctrl_prev) begin
                  r_shreg <= w_shift_next;
                  r_cnt   <= CNT_W'(1);
                  r_state <= S_SHIFT;
                  r_busy  <= 1'b1;
               end
            end

            S_SHIFT: begin
               if (w_ctrl_s) begin
                  if (r_cnt == CNT_W'(WIDTH)) begin
                     // Bit WIDTH+1 still enabled: frame is too long.
                     r_state <= S_OVERRUN;
                  end else begin
                     r_shreg <= w_shift_next;
                     r_cnt   <= r_cnt + CNT_W'(1);
                  end
               end else begin
                  if (r_cnt == CNT_W'(WIDTH)) begin
                     r_word_out    <= r_shreg;
                     r_word_valid  <= 1'b1;
                     r_good_frames <= r_good_frames + 8'd1;
                  end else begin
                     r_frame_error <= 1'b1;
                  end
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end

            S_OVERRUN: begin
               // Single error pulse, issued once the far end releases ctrl.
               if (!w_ctrl_s) begin
                  r_frame_error <= 1'b1;
                  r_state       <= S_IDLE;
                  r_busy        <= 1'b0;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign word_out    = r_word_out;
   assign word_valid  = r_word_valid;
   assign frame_error = r_frame_error;
   assign busy        = r_busy;
   assign good_frames = r_good_frames;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Purpose : directed self-checking bench for serial_word_receiver.
// Latency : inputs driven on the falling edge, outputs observed on the next falling edge.
// Backpressure: none.
module tb_serial_word_receiver;

`ifdef RX_INPUT_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   localparam int WIDTH = 18;

   logic             clk;
   logic             reset;
   logic             din;
   logic             ctrl;
   logic [WIDTH-1:0] word_out;
   logic             word_valid;
   logic             frame_error;
   logic             busy;
   logic [7:0]       good_frames;

   int n_tests;
   int n_fail;
   int cyc;
   int n_valid;
   int n_err;
   int n_both;
   int n_busy;
   int last_valid_cyc;
   int last_err_cyc;
   int drop_cyc;

   serial_word_receiver #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .Ten_MHz_input_clock (clk),
      .reset               (reset),
      .input_data_1_bit    (din),
      .data_ctrl_input     (ctrl),
      .word_out            (word_out),
      .word_valid          (word_valid),
      .frame_error         (frame_error),
      .busy                (busy),
      .good_frames         (good_frames)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   // One cycle: observe outputs of the previous rising edge, then drive new inputs.
   task automatic tick(input logic c, input logic d, input logic r);
      @(negedge clk);
      cyc++;
      if (word_valid === 1'b1) begin
         n_valid++;
         last_valid_cyc = cyc;
      end
      if (frame_error === 1'b1) begin
         n_err++;
         last_err_cyc = cyc;
      end
      if (word_valid === 1'b1 && frame_error === 1'b1) n_both++;
      if (busy === 1'b1) n_busy++;
      ctrl  = c;
      din   = d;
      reset = r;
   endtask

   // nhigh ctrl-high cycles (MSB first, zeros past WIDTH), then gap low cycles.
   task automatic send_frame(input logic [WIDTH-1:0] w, input int nhigh, input int gap);
      logic b;
      for (int i = 0; i < nhigh; i++) begin
         b = (i < WIDTH) ? w[WIDTH-1-i] : 1'b0;
         tick(1'b1, b, 1'b0);
      end
      tick(1'b0, 1'b0, 1'b0);
      drop_cyc = cyc;
      for (int i = 1; i < gap; i++) tick(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
      n_tests++; if (word_out !== 18'h00000) begin n_fail++; $display("FAIL reset_word_out: got %h expected %h", word_out, 18'h00000); end
      n_tests++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_word_valid: got %b expected 0", word_valid); end
      n_tests++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_tests++; if (good_frames !== 8'd0) begin n_fail++; $display("FAIL reset_good_frames: got %0d expected 0", good_frames); end
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_good_frame();
      int v0, e0, b0;
      do_reset();
      v0 = n_valid; e0 = n_err; b0 = n_busy;
      send_frame(18'h2A5C3, 18, 6);
      n_tests++; if (word_out !== 18'h2A5C3) begin n_fail++; $display("FAIL good_word_out: got %h expected %h", word_out, 18'h2A5C3); end
      n_tests++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL good_valid_pulses: got %0d expected 1", n_valid - v0); end
      n_tests++; if (good_frames !== 8'd1) begin n_fail++; $display("FAIL good_count: got %0d expected 1", good_frames); end
      n_tests++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL good_no_error: got %0d expected 0", n_err - e0); end
      n_tests++; if (n_busy - b0 !== 18) begin n_fail++; $display("FAIL good_busy_cycles: got %0d expected 18", n_busy - b0); end
      n_tests++; if (last_valid_cyc - drop_cyc !== 1 + LAT) begin n_fail++; $display("FAIL good_latency: got %0d expected %0d", last_valid_cyc - drop_cyc, 1 + LAT); end
   endtask

   task automatic test_short_frame();
      int v0, e0;
      do_reset();
      send_frame(18'h00FF0, 18, 6);
      v0 = n_valid; e0 = n_err;
      send_frame(18'h3FFFF, 10, 6);
      n_tests++; if (n_err - e0 !== 1) begin n_fail++; $display("FAIL short_error_pulses: got %0d expected 1", n_err - e0); end
      n_tests++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL short_no_valid: got %0d expected 0", n_valid - v0); end
      n_tests++; if (word_out !== 18'h00FF0) begin n_fail++; $display("FAIL short_word_kept: got %h expected %h", word_out, 18'h00FF0); end
      n_tests++; if (good_frames !== 8'd1) begin n_fail++; $display("FAIL short_count_kept: got %0d expected 1", good_frames); end
      n_tests++; if (last_err_cyc - drop_cyc !== 1 + LAT) begin n_fail++; $display("FAIL short_err_latency: got %0d expected %0d", last_err_cyc - drop_cyc, 1 + LAT); end
   endtask

   task automatic test_overrun();
      int v0, e0, b0;
      do_reset();
      v0 = n_valid; e0 = n_err; b0 = n_busy;
      send_frame(18'h15555, 20, 6);
      n_tests++; if (n_busy - b0 !== 20) begin n_fail++; $display("FAIL over_busy_cycles: got %0d expected 20", n_busy - b0); end
      n_tests++; if (n_err - e0 !== 1) begin n_fail++; $display("FAIL over_error_pulses: got %0d expected 1", n_err - e0); end
      n_tests++; if (last_err_cyc - drop_cyc !== 1 + LAT) begin n_fail++; $display("FAIL over_err_latency: got %0d expected %0d", last_err_cyc - drop_cyc, 1 + LAT); end
      n_tests++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL over_no_valid: got %0d expected 0", n_valid - v0); end
      n_tests++; if (word_out !== 18'h00000) begin n_fail++; $display("FAIL over_word_kept: got %h expected %h", word_out, 18'h00000); end
   endtask

   task automatic test_back_to_back();
      int v0;
      do_reset();
      v0 = n_valid;
      send_frame(18'h3FFFF, 18, 1);
      send_frame(18'h00001, 18, 6);
      n_tests++; if (n_valid - v0 !== 2) begin n_fail++; $display("FAIL b2b_valid_pulses: got %0d expected 2", n_valid - v0); end
      n_tests++; if (word_out !== 18'h00001) begin n_fail++; $display("FAIL b2b_word_out: got %h expected %h", word_out, 18'h00001); end
      n_tests++; if (good_frames !== 8'd2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", good_frames); end
   endtask

   task automatic test_reset_mid_frame();
      logic [WIDTH-1:0] w;
      int v0, e0, b0;
      do_reset();
      w = 18'h3C3C3;
      v0 = n_valid; e0 = n_err;
      for (int i = 0; i < 7; i++) tick(1'b1, w[WIDTH-1-i], 1'b0);
      tick(1'b1, 1'b1, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      b0 = n_busy;
      for (int i = 0; i < 11; i++) tick(1'b1, i[0], 1'b0);
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0);
      n_tests++; if (n_busy - b0 !== 0) begin n_fail++; $display("FAIL midrst_busy: got %0d expected 0", n_busy - b0); end
      n_tests++; if (n_valid - v0 !== 0 || n_err - e0 !== 0) begin n_fail++; $display("FAIL midrst_pulses: got %0d/%0d expected 0/0", n_valid - v0, n_err - e0); end
      n_tests++; if (word_out !== 18'h00000) begin n_fail++; $display("FAIL midrst_word_out: got %h expected %h", word_out, 18'h00000); end
      send_frame(18'h12345, 18, 6);
      n_tests++; if (word_out !== 18'h12345) begin n_fail++; $display("FAIL midrst_next_word: got %h expected %h", word_out, 18'h12345); end
      n_tests++; if (good_frames !== 8'd1) begin n_fail++; $display("FAIL midrst_count: got %0d expected 1", good_frames); end
   endtask

   task automatic test_wrap();
      int v0;
      do_reset();
      v0 = n_valid;
      for (int i = 0; i < 255; i++) send_frame(18'(i), 18, 1);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
      n_tests++; if (good_frames !== 8'd255) begin n_fail++; $display("FAIL wrap_count_255: got %0d expected 255", good_frames); end
      n_tests++; if (word_out !== 18'h000FE) begin n_fail++; $display("FAIL wrap_word_254: got %h expected %h", word_out, 18'h000FE); end
      send_frame(18'h3ABCD, 18, 6);
      n_tests++; if (good_frames !== 8'd0) begin n_fail++; $display("FAIL wrap_count_0: got %0d expected 0", good_frames); end
      n_tests++; if (word_out !== 18'h3ABCD) begin n_fail++; $display("FAIL wrap_last_word: got %h expected %h", word_out, 18'h3ABCD); end
      n_tests++; if (n_valid - v0 !== 256) begin n_fail++; $display("FAIL wrap_valid_pulses: got %0d expected 256", n_valid - v0); end
   endtask

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0;
      n_valid = 0; n_err = 0; n_both = 0; n_busy = 0;
      last_valid_cyc = -1; last_err_cyc = -1; drop_cyc = 0;
      reset = 1'b1; ctrl = 1'b0; din = 1'b0;

      test_reset();
      test_good_frame();
      test_short_frame();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      test_wrap();

      n_tests++; if (n_both !== 0) begin n_fail++; $display("FAIL valid_and_error_together: got %0d expected 0", n_both); end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
